// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern modes, bar colours
// and the 640x480@60 timing preset (25 MHz pixel clock).
package video_pkg;

    typedef enum logic [1:0] {
        MODE_GRAD  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Bar colours as {R,G,B} on/off masks, expanded to full channels at use.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    localparam int VGA640_PIXCLK_HZ = 25_000_000;
    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active, sync and frame-boundary decodes.
module video_timing_counter
    import video_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int CNT_W    = 12
) (
    input  logic             pixclk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             de_act,
    output logic             hs_act,
    output logic             vs_act,
    output logic             frame_end
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             h_last, v_last;

    always_comb begin
        h_last = (hcnt_q == CNT_W'(H_TOTAL - 1));
        v_last = (vcnt_q == CNT_W'(V_TOTAL - 1));
        hcnt_d = h_last ? '0 : hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (h_last) begin
            vcnt_d = v_last ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign de_act    = (hcnt_q < CNT_W'(H_ACTIVE)) && (vcnt_q < CNT_W'(V_ACTIVE));
    assign hs_act    = (hcnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (hcnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    // vcnt only moves on the hcnt wrap, so vsync edges land there too.
    assign vs_act    = (vcnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (vcnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_end = h_last && v_last;

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: gradient, colour bars, checkerboard or
// solid colour, with mode and colour latched once per frame.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 12
) (
    input  logic                 pixclk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [CNT_W-1:0]     x,
    output logic [CNT_W-1:0]     y,
    output logic                 frame_start,
    output logic [7:0]           frame_cnt
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             de_act, hs_act, vs_act, frame_end;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .de_act    (de_act),
        .hs_act    (hs_act),
        .vs_act    (vs_act),
        .frame_end (frame_end)
    );

    mode_e                mode_q, mode_d;
    logic [3*COLOR_W-1:0] color_q, color_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CNT_W-1:0]     x_q, x_d, y_q, y_d;
    logic                 frame_start_q, frame_start_d;
    logic [2:0]           bar_idx, bar_c;
    logic [CNT_W-1:0]     xy_sum;

    always_comb begin
        mode_d      = mode_q;
        color_d     = color_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_end) begin
            mode_d      = mode_e'(mode);
            color_d     = solid_rgb;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // Bar index = min(x / BAR_W, 7) via threshold compares.
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcnt >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
        end
        bar_c  = bar_color(bar_idx);
        xy_sum = hcnt + vcnt;

        case (mode_q)
            MODE_GRAD:  rgb_d = {hcnt[COLOR_W-1:0], vcnt[COLOR_W-1:0], xy_sum[COLOR_W-1:0]};
            MODE_BARS:  rgb_d = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
            MODE_CHECK: rgb_d = (hcnt[4] ^ vcnt[4]) ? '1 : '0;
            MODE_SOLID: rgb_d = color_q;
            default:    rgb_d = '0;
        endcase
        if (!de_act) rgb_d = '0;

        hsync_d       = hs_act ? HS_POL : ~HS_POL;
        vsync_d       = vs_act ? VS_POL : ~VS_POL;
        de_d          = de_act;
        x_d           = hcnt;
        y_d           = vcnt;
        frame_start_d = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_GRAD;
            color_q       <= '0;
            frame_cnt_q   <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            color_q       <= color_d;
            frame_cnt_q   <= frame_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hsync              = hsync_q;
    assign vsync              = vsync_q;
    assign de                 = de_q;
    assign x                  = x_q;
    assign y                  = y_q;
    assign frame_start        = frame_start_q;
    assign frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: per-cycle comparison against a raster model with
// randomized mode changes, plus a tiny-raster instance for frame counter wrap.
module tb_video_pattern_gen;

    localparam int HA = 44, HFP = 3, HSY = 4, HBP = 5;
    localparam int VA = 36, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;
    localparam int BW = HA / 8;
    localparam int FR2 = (8 + 1 + 2 + 1) * (4 + 1 + 1 + 1);

    logic        pixclk = 1'b0;
    logic        rst_n, rst2_n;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] x, y;
    logic [7:0]  frame_cnt;

    logic [7:0]  red_s, green_s, blue_s;
    logic        hsync_s, vsync_s, de_s, frame_start_s;
    logic [11:0] x_s, y_s;
    logic [7:0]  frame_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;
    bit run     = 1'b0;
    logic [1:0]  fmode  [64];
    logic [23:0] fsolid [64];
    int ms, mh, mv, mf;

    always #5 pixclk = ~pixclk;

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .COLOR_W (8), .CNT_W (12)
    ) dut (
        .pixclk (pixclk), .rst_n (rst_n), .mode (mode), .solid_rgb (solid_rgb),
        .red (red), .green (green), .blue (blue),
        .hsync (hsync), .vsync (vsync), .de (de), .x (x), .y (y),
        .frame_start (frame_start), .frame_cnt (frame_cnt)
    );

    video_pattern_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .COLOR_W (8), .CNT_W (12)
    ) dut_small (
        .pixclk (pixclk), .rst_n (rst2_n), .mode (2'd0), .solid_rgb (24'd0),
        .red (red_s), .green (green_s), .blue (blue_s),
        .hsync (hsync_s), .vsync (vsync_s), .de (de_s), .x (x_s), .y (y_s),
        .frame_start (frame_start_s), .frame_cnt (frame_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int h, input int v,
                                            input logic [1:0] m, input logic [23:0] c);
        int idx;
        if (!(h < HA && v < VA)) return 24'h0;
        case (m)
            2'd0: return {8'(h), 8'(v), 8'(h + v)};
            2'd1: begin
                idx = h / BW;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd2: return ((((h / 16) ^ (v / 16)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return c;
        endcase
    endfunction

    // n is the raster state the counters hold during this cycle; outputs show state n-1.
    always @(negedge pixclk) begin
        if (run) begin
            if (n == 0) begin
                chk("idle_after_release", {hsync, vsync, de, frame_start}, 4'b1100);
            end else begin
                ms = n - 1;
                mh = ms % HT;
                mv = (ms / HT) % VT;
                mf = ms / FR;
                chk("sync", {hsync, vsync, de},
                    {!(mh >= HA + HFP && mh < HA + HFP + HSY),
                     !(mv >= VA + VFP && mv < VA + VFP + VSY),
                     (mh < HA && mv < VA)});
                chk("rgb", {red, green, blue}, exp_rgb(mh, mv, fmode[mf], fsolid[mf]));
                chk("xy", {x, y}, {12'(mh), 12'(mv)});
                chk("fs_fcnt", {frame_start, frame_cnt},
                    {(mh == 0 && mv == 0), 8'((ms + 1) / FR)});
            end
            if ((n % FR) == FR - 1 && (n / FR) + 1 < 64) begin
                fmode[(n / FR) + 1]  = mode;
                fsolid[(n / FR) + 1] = solid_rgb;
            end
            n++;
        end
    end

    task automatic wait_state(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 4 * FR) begin
            @(posedge pixclk);
            #2;
            guard++;
        end
        if (n < target) chk("wait_timeout", 64'(n), 64'(target));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_sync"}, {hsync, vsync, de}, 3'b110);
        chk({pfx, "_rgb"}, {red, green, blue}, 24'h0);
        chk({pfx, "_xy"}, {x, y}, 24'h0);
        chk({pfx, "_fs_fcnt"}, {frame_start, frame_cnt}, 9'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rst2_n    = 1'b0;
        mode      = 2'd1;
        solid_rgb = 24'hABCDEF;
        fork
            begin : main_seq
                repeat (3) @(posedge pixclk);
                @(negedge pixclk);
                chk_reset_vals("rst_hold");
                @(posedge pixclk);
                #1;
                fmode[0] = 2'd0; fsolid[0] = 24'h0; n = 0; run = 1'b1;
                rst_n = 1'b1;
                for (int f = 0; f < 9; f++) begin
                    wait_state(f * FR + $urandom_range(1, FR / 2));
                    mode      = 2'($urandom_range(0, 3));
                    solid_rgb = 24'($urandom);
                    wait_state(f * FR + $urandom_range(FR / 2 + 1, FR - 1));
                    mode      = 2'((f + 1) % 4);
                    solid_rgb = 24'($urandom);
                end
                wait_state(9 * FR + 20 * HT + 30);
                chk("pre_reset_de", {31'd0, de}, 1);
                mode      = 2'd3;
                solid_rgb = 24'h123456;
                run       = 1'b0;
                rst_n     = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                @(posedge pixclk);
                #1;
                fmode[0] = 2'd0; fsolid[0] = 24'h0; n = 0; run = 1'b1;
                rst_n = 1'b1;
                wait_state(3 * FR);
                run = 1'b0;
            end
            begin : small_seq
                int cyc, k;
                repeat (2) @(posedge pixclk);
                @(negedge pixclk);
                chk("s_rst_sync", {hsync_s, vsync_s, de_s, frame_start_s}, 4'b0000);
                chk("s_rst_data", {red_s, green_s, blue_s, x_s, y_s, frame_cnt_s}, 64'h0);
                @(posedge pixclk);
                #1;
                rst2_n = 1'b1;
                cyc = 0;
                k = 0;
                while (k < 258 && cyc < 260 * FR2) begin
                    @(negedge pixclk);
                    cyc++;
                    if (frame_start_s) begin
                        chk("s_fs_cycle", 64'(cyc), 64'(k * FR2 + 2));
                        chk("s_fcnt", {56'd0, frame_cnt_s}, 64'(k % 256));
                        k++;
                    end
                end
                if (k < 258) chk("s_timeout", 64'(k), 64'd258);
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
